// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with load-use bubble insertion and EX/MEM, MEM/WB operand forwarding.
// Optional load-use bubble counter enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_operand_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [3:0]        id_alu_op,
  input  logic              id_src1_pc,
  input  logic              id_src2_imm,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              flush,
  input  logic              ex_ready,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic              exm_reg_write,
  input  logic [XLEN-1:0]   exm_result,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic              mwb_reg_write,
  input  logic [XLEN-1:0]   mwb_result,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_in1,
  output logic [XLEN-1:0]   ex_in2,
  output logic [3:0]        ex_alu_op,
  output logic [XLEN-1:0]   ex_rs2_fwd,
  output logic [XLEN-1:0]   ex_pc,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [31:0]       stall_count
);

  logic [XLEN-1:0]   rs1_data_q;
  logic [XLEN-1:0]   rs2_data_q;
  logic [XLEN-1:0]   imm_q;
  logic [REG_AW-1:0] rs1_q;
  logic [REG_AW-1:0] rs2_q;
  logic              src1_pc_q;
  logic              src2_imm_q;
  logic              hz;
  logic [XLEN-1:0]   fwd_rs1;
  logic [XLEN-1:0]   fwd_rs2;

  // Load in EX whose rd feeds an operand actually read by the incoming instruction
  always_comb begin
    hz = ex_valid && ex_mem_read && (ex_rd != '0) &&
         (((ex_rd == id_rs1) && !id_src1_pc) ||
          ((ex_rd == id_rs2) && (!id_src2_imm || id_mem_write)));
    id_ready = ex_ready && !hz;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      ex_rd        <= '0;
      ex_alu_op    <= '0;
      src1_pc_q    <= 1'b0;
      src2_imm_q   <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (ex_ready) begin
      if (hz) begin
        ex_valid     <= 1'b0;
        ex_reg_write <= 1'b0;
        ex_mem_read  <= 1'b0;
        ex_mem_write <= 1'b0;
      end else begin
        ex_valid     <= id_valid;
        ex_pc        <= id_pc;
        rs1_data_q   <= id_rs1_data;
        rs2_data_q   <= id_rs2_data;
        imm_q        <= id_imm;
        rs1_q        <= id_rs1;
        rs2_q        <= id_rs2;
        ex_rd        <= id_rd;
        ex_alu_op    <= id_alu_op;
        src1_pc_q    <= id_src1_pc;
        src2_imm_q   <= id_src2_imm;
        ex_reg_write <= id_reg_write && id_valid;
        ex_mem_read  <= id_mem_read && id_valid;
        ex_mem_write <= id_mem_write && id_valid;
      end
    end
  end

  // Forwarding is evaluated every cycle on held state so stalled operands stay current
  always_comb begin
    if (exm_reg_write && (exm_rd != '0) && (exm_rd == rs1_q))
      fwd_rs1 = exm_result;
    else if (mwb_reg_write && (mwb_rd != '0) && (mwb_rd == rs1_q))
      fwd_rs1 = mwb_result;
    else
      fwd_rs1 = rs1_data_q;

    if (exm_reg_write && (exm_rd != '0) && (exm_rd == rs2_q))
      fwd_rs2 = exm_result;
    else if (mwb_reg_write && (mwb_rd != '0) && (mwb_rd == rs2_q))
      fwd_rs2 = mwb_result;
    else
      fwd_rs2 = rs2_data_q;

    ex_in1     = src1_pc_q  ? ex_pc : fwd_rs1;
    ex_in2     = src2_imm_q ? imm_q : fwd_rs2;
    ex_rs2_fwd = fwd_rs2;
  end

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt_q <= '0;
    else if (!flush && ex_ready && hz)
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: capture vectors, forwarding, load-use, stall, flush, reset.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_ready;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_op;
  logic        id_src1_pc, id_src2_imm, id_reg_write, id_mem_read, id_mem_write;
  logic        flush, ex_ready;
  logic [4:0]  exm_rd, mwb_rd;
  logic        exm_reg_write, mwb_reg_write;
  logic [31:0] exm_result, mwb_result;
  logic        ex_valid;
  logic [31:0] ex_in1, ex_in2, ex_rs2_fwd, ex_pc;
  logic [3:0]  ex_alu_op;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic [31:0] stall_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_cnt;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
    .id_src1_pc(id_src1_pc), .id_src2_imm(id_src2_imm), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .flush(flush), .ex_ready(ex_ready),
    .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
    .mwb_rd(mwb_rd), .mwb_reg_write(mwb_reg_write), .mwb_result(mwb_result),
    .ex_valid(ex_valid), .ex_in1(ex_in1), .ex_in2(ex_in2), .ex_alu_op(ex_alu_op),
    .ex_rs2_fwd(ex_rs2_fwd), .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .stall_count(stall_count)
  );

  typedef struct {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  op;
    logic        s1pc, s2imm, rw, mr, mw;
    logic        e_valid;
    logic [31:0] e_in1, e_in2, e_fwd2;
    logic        e_rw, e_mr, e_mw;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] r1d,
                       input logic [31:0] r2d, input logic [31:0] imm, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] rd, input logic [3:0] op,
                       input logic s1pc, input logic s2imm, input logic rw, input logic mr,
                       input logic mw);
    id_valid = v; id_pc = pc; id_rs1_data = r1d; id_rs2_data = r2d; id_imm = imm;
    id_rs1 = r1; id_rs2 = r2; id_rd = rd; id_alu_op = op; id_src1_pc = s1pc;
    id_src2_imm = s2imm; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //        v  pc        rs1d          rs2d          imm           rs1 rs2 rd  op s1 s2 rw mr mw | ev in1          in2           fwd2          rw mr mw
    vecs[0] = '{1, 32'h64,  32'h5,        32'h9,        32'h7,        1,  2,  3,  0, 0, 1, 1, 0, 0,  1, 32'h5,       32'h7,        32'h9,        1, 0, 0};
    vecs[1] = '{1, 32'h200, 32'h11,       32'h22,       32'h33,       5,  6,  7,  3, 1, 0, 1, 0, 0,  1, 32'h200,     32'h22,       32'h22,       1, 0, 0};
    vecs[2] = '{0, 32'h300, 32'h44,       32'h66,       32'h55,       0,  0,  9,  2, 0, 1, 1, 1, 1,  0, 32'h44,      32'h55,       32'h66,       0, 0, 0};
    vecs[3] = '{1, 32'h400, 32'h1000,     32'h0,        32'h4,        1,  2,  8,  0, 0, 1, 1, 1, 0,  1, 32'h1000,    32'h4,        32'h0,        1, 1, 0};
    vecs[4] = '{1, 32'h404, 32'hdeadbeef, 32'hcafef00d, 32'hfffffffc, 9,  10, 0,  0, 0, 1, 0, 0, 1,  1, 32'hdeadbeef, 32'hfffffffc, 32'hcafef00d, 0, 0, 1};
    vecs[5] = '{1, 32'h408, 32'hffffffff, 32'h80000000, 32'h1,        31, 30, 31, 15, 0, 0, 1, 0, 0, 1, 32'hffffffff, 32'h80000000, 32'h80000000, 1, 0, 0};

    exp_cnt = 32'd0;
    rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    exm_rd = 5'd0; exm_reg_write = 1'b0; exm_result = 32'h0;
    mwb_rd = 5'd0; mwb_reg_write = 1'b0; mwb_result = 32'h0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("reset ex_valid", 32'(ex_valid), 32'd0);
    chk("reset ex_alu_op", 32'(ex_alu_op), 32'd0);
    chk("reset ex_in1", ex_in1, 32'd0);
    chk("reset stall_count", stall_count, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].valid, vecs[i].pc, vecs[i].rs1d, vecs[i].rs2d, vecs[i].imm, vecs[i].rs1,
            vecs[i].rs2, vecs[i].rd, vecs[i].op, vecs[i].s1pc, vecs[i].s2imm, vecs[i].rw,
            vecs[i].mr, vecs[i].mw);
      #1;
      chk($sformatf("vec%0d id_ready", i), 32'(id_ready), 32'd1);
      tick();
      chk($sformatf("vec%0d ex_valid", i), 32'(ex_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d ex_in1", i), ex_in1, vecs[i].e_in1);
      chk($sformatf("vec%0d ex_in2", i), ex_in2, vecs[i].e_in2);
      chk($sformatf("vec%0d ex_rs2_fwd", i), ex_rs2_fwd, vecs[i].e_fwd2);
      chk($sformatf("vec%0d ex_alu_op", i), 32'(ex_alu_op), 32'(vecs[i].op));
      chk($sformatf("vec%0d ex_pc", i), ex_pc, vecs[i].pc);
      chk($sformatf("vec%0d ex_rd", i), 32'(ex_rd), 32'(vecs[i].rd));
      chk($sformatf("vec%0d ctrl", i), 32'({ex_reg_write, ex_mem_read, ex_mem_write}),
          32'({vecs[i].e_rw, vecs[i].e_mr, vecs[i].e_mw}));
    end

    // Forwarding priority on a held instruction reading x3 on both sources
    drive(1, 32'h500, 32'h33, 32'h44, 32'h0, 3, 3, 1, 0, 0, 0, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exm_rd = 5'd3; exm_reg_write = 1'b1; exm_result = 32'hAA;
    mwb_rd = 5'd3; mwb_reg_write = 1'b1; mwb_result = 32'hBB;
    #1;
    chk("fwd exm ex_in1", ex_in1, 32'hAA);
    chk("fwd exm ex_rs2_fwd", ex_rs2_fwd, 32'hAA);
    exm_reg_write = 1'b0; #1;
    chk("fwd mwb ex_in1", ex_in1, 32'hBB);
    chk("fwd mwb ex_in2", ex_in2, 32'hBB);
    exm_reg_write = 1'b1; exm_rd = 5'd0; mwb_rd = 5'd0; #1;
    chk("fwd x0 ex_in1", ex_in1, 32'h33);
    chk("fwd x0 ex_rs2_fwd", ex_rs2_fwd, 32'h44);
    exm_reg_write = 1'b0; mwb_reg_write = 1'b0;

    // Load-use on rs1: one bubble, then accept
    drive(1, 32'h600, 32'h0, 32'h0, 32'h0, 1, 2, 4, 0, 0, 1, 1, 1, 0);
    tick();
    drive(1, 32'h604, 32'h77, 32'h0, 32'h8, 4, 0, 5, 0, 0, 1, 1, 0, 0);
    #1;
    chk("loaduse id_ready low", 32'(id_ready), 32'd0);
    tick();
    exp_cnt = exp_cnt + 32'd1;
    chk("loaduse bubble ex_valid", 32'(ex_valid), 32'd0);
    chk("loaduse bubble mem_read", 32'(ex_mem_read), 32'd0);
    chk("loaduse id_ready high", 32'(id_ready), 32'd1);
`ifdef ID_EX_PERF_CNT_EN
    chk("loaduse stall_count", stall_count, exp_cnt);
`else
    chk("loaduse stall_count", stall_count, 32'd0);
`endif
    tick();
    chk("loaduse accept ex_valid", 32'(ex_valid), 32'd1);
    chk("loaduse accept ex_in1", ex_in1, 32'h77);
    chk("loaduse accept ex_rd", 32'(ex_rd), 32'd5);

    // Store data dependency counts even with an immediate operand; rd=0 load never stalls
    drive(1, 32'h700, 32'h0, 32'h0, 32'h0, 1, 2, 6, 0, 0, 1, 1, 1, 0);
    tick();
    drive(1, 32'h704, 32'h0, 32'h12, 32'h4, 1, 6, 0, 0, 0, 1, 0, 0, 1);
    #1;
    chk("store hz id_ready", 32'(id_ready), 32'd0);
    tick();
    exp_cnt = exp_cnt + 32'd1;
    tick();
    chk("store accept ex_mem_write", 32'(ex_mem_write), 32'd1);
    chk("store accept ex_rs2_fwd", ex_rs2_fwd, 32'h12);
    drive(1, 32'h708, 32'h0, 32'h0, 32'h0, 1, 2, 0, 0, 0, 1, 1, 1, 0);
    tick();
    drive(1, 32'h70c, 32'h0, 32'h0, 32'h0, 0, 0, 3, 0, 0, 0, 1, 0, 0);
    #1;
    chk("rd0 load id_ready", 32'(id_ready), 32'd1);
`ifdef ID_EX_PERF_CNT_EN
    chk("stall_count after two", stall_count, exp_cnt);
`endif

    // Downstream stall for three cycles with live forwarding
    drive(1, 32'h800, 32'h10, 32'h0, 32'h0, 5, 0, 9, 6, 0, 1, 1, 0, 0);
    tick();
    ex_ready = 1'b0;
    drive(1, 32'h900, 32'h20, 32'h0, 32'h0, 7, 0, 11, 1, 0, 1, 1, 0, 0);
    exm_rd = 5'd5; exm_reg_write = 1'b1; exm_result = 32'h99;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("stall%0d ex_valid", c), 32'(ex_valid), 32'd1);
      chk($sformatf("stall%0d ex_rd", c), 32'(ex_rd), 32'd9);
      chk($sformatf("stall%0d id_ready", c), 32'(id_ready), 32'd0);
      chk($sformatf("stall%0d ex_in1", c), ex_in1, exm_result);
      exm_result = exm_result + 32'h1;
    end
    exm_reg_write = 1'b0; #1;
    chk("stall unforwarded ex_in1", ex_in1, 32'h10);

    // Flush while stalled with a valid incoming instruction
    flush = 1'b1;
    drive(1, 32'hA00, 32'h0, 32'h0, 32'h0, 0, 0, 12, 2, 0, 1, 1, 0, 0);
    tick();
    flush = 1'b0;
    chk("flush ex_valid", 32'(ex_valid), 32'd0);
    chk("flush not captured ex_rd", 32'(ex_rd), 32'd9);

    // Async reset in the middle of a stall
    ex_ready = 1'b1;
    drive(1, 32'hB00, 32'h5, 32'h0, 32'h0, 1, 0, 13, 7, 0, 1, 1, 0, 0);
    tick();
    ex_ready = 1'b0;
    tick();
    chk("pre-reset ex_valid", 32'(ex_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset ex_valid", 32'(ex_valid), 32'd0);
    chk("async reset ex_alu_op", 32'(ex_alu_op), 32'd0);
    chk("async reset stall_count", stall_count, 32'd0);
    tick();
    rst_n = 1'b1;
    ex_ready = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
